// File: rtl/pim_pkg.sv
// Shared types and tables for the bit-sliced PIM conv sequencer.
// Phases walk data-hi/lo x weight-hi/lo with matching accumulate shifts.
package pim_pkg;

    localparam int SLICE_W  = 3;
    localparam int NUM_ELEM = 25;
    localparam int WIN_W    = NUM_ELEM * 2 * SLICE_W;
    localparam int FEAT_W   = NUM_ELEM * SLICE_W;

    typedef enum logic [1:0] {PH_HH, PH_HL, PH_LH, PH_LL} phase_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_OUT} state_e;

    localparam logic [2:0] PH_SHIFT [4] = '{3'd6, 3'd3, 3'd3, 3'd0};
    localparam logic       PH_WSEL  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic       PH_DHI   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    function automatic logic [FEAT_W-1:0] data_slice(
        input logic [WIN_W-1:0] win,
        input logic             hi
    );
        logic [FEAT_W-1:0] s;
        s = '0;
        for (int e = 0; e < NUM_ELEM; e++) begin
            s[e*SLICE_W +: SLICE_W] = hi ? win[e*2*SLICE_W+SLICE_W +: SLICE_W]
                                         : win[e*2*SLICE_W +: SLICE_W];
        end
        return s;
    endfunction

endpackage

// File: rtl/pim_shift_acc.sv
// Clear / shift-accumulate register for unsigned crossbar slice results.
module pim_shift_acc #(
    parameter int ADC_P = 6,
    parameter int ACC_W = ADC_P + 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             acc_i,
    input  logic [2:0]       shift_i,
    input  logic [ADC_P-1:0] val_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (acc_i) begin
            acc_d = acc_q + (ACC_W'(val_i) << shift_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pim_conv_seq.sv
// Sequencer for a shared 5x5 bit-sliced PIM crossbar: four slice ops per
// kernel, shift-accumulated, one result per kernel out.
module pim_conv_seq
    import pim_pkg::*;
#(
    parameter int NUM_KERNELS = 6,
    parameter int ADDR_W      = 5,
    parameter int ADC_P       = 6,
    parameter int PIM_LAT     = 1,
    parameter int OUT_W       = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIN_W-1:0]  in_window,
    output logic              pim_en,
    output logic [ADDR_W-1:0] pim_addr,
    output logic [FEAT_W-1:0] pim_feature,
    input  logic [ADC_P-1:0]  pim_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [2:0]        out_kidx,
    output logic              out_last
);

    localparam int ACC_W = ADC_P + 7;
    localparam int LAT_W = $clog2(PIM_LAT + 1);
    localparam logic [2:0]       LAST_K   = 3'(NUM_KERNELS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIM_LAT - 1);

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [2:0]       kidx_q, kidx_d;
    logic [LAT_W-1:0] wcnt_q, wcnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             acc_clr, acc_en;
    logic [ACC_W-1:0] acc;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        kidx_d      = kidx_q;
        wcnt_d      = wcnt_q;
        win_d       = win_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        in_ready    = 1'b0;
        pim_en      = 1'b0;
        pim_addr    = '0;
        pim_feature = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_kidx    = '0;
        out_last    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    win_d   = in_window;
                    kidx_d  = '0;
                    phase_d = PH_HH;
                    acc_clr = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pim_en      = 1'b1;
                pim_addr    = ADDR_W'({kidx_q, PH_WSEL[phase_q]});
                pim_feature = data_slice(win_q, PH_DHI[phase_q]);
                wcnt_d      = LAT_LAST;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    // pim_result is only trusted on the final wait cycle
                    acc_en = 1'b1;
                    if (phase_q == PH_LL) begin
                        state_d = ST_OUT;
                    end else begin
                        phase_d = phase_e'(phase_q + 2'd1);
                        state_d = ST_ISSUE;
                    end
                end else begin
                    wcnt_d = wcnt_q - LAT_W'(1);
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                out_data  = OUT_W'(acc);
                out_kidx  = kidx_q;
                out_last  = (kidx_q == LAST_K);
                if (out_ready) begin
                    if (kidx_q == LAST_K) begin
                        state_d = ST_IDLE;
                    end else begin
                        kidx_d  = kidx_q + 3'd1;
                        phase_d = PH_HH;
                        acc_clr = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= PH_HH;
            kidx_q  <= '0;
            wcnt_q  <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            kidx_q  <= kidx_d;
            wcnt_q  <= wcnt_d;
            win_q   <= win_d;
        end
    end

    pim_shift_acc #(
        .ADC_P (ADC_P),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (acc_clr),
        .acc_i   (acc_en),
        .shift_i (PH_SHIFT[phase_q]),
        .val_i   (pim_result),
        .acc_o   (acc)
    );

endmodule

// File: tb/tb_pim_conv_seq.sv
// Bench for pim_conv_seq: PIM_LAT=1 and PIM_LAT=3 instances, a crossbar
// fixture, and a per-window result/op model checked every cycle.
module tb_pim_conv_seq;

    localparam int NK = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]        in_valid  = '0;
    logic [1:0]        in_ready;
    logic [1:0][149:0] in_window = '0;
    logic [1:0]        pim_en;
    logic [1:0][4:0]   pim_addr;
    logic [1:0][74:0]  pim_feature;
    logic [1:0][5:0]   pim_result = '0;
    logic [1:0]        out_valid;
    logic [1:0]        out_ready = 2'b11;
    logic [1:0][17:0]  out_data;
    logic [1:0][2:0]   out_kidx;
    logic [1:0]        out_last;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pim_conv_seq #(.PIM_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .in_window   (in_window[g]),
            .pim_en      (pim_en[g]),
            .pim_addr    (pim_addr[g]),
            .pim_feature (pim_feature[g]),
            .pim_result  (pim_result[g]),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready[g]),
            .out_data    (out_data[g]),
            .out_kidx    (out_kidx[g]),
            .out_last    (out_last[g])
        );
    end

    // ---------------- model ----------------
    int         mode = 0;      // 0: 1/2/3/4 per phase, 1: all 63, 2: weighted sum
    logic [2:0] W [32][25];
    int         rmode = 0;     // 0: ready high, 1: random, 2: stall kernel 2
    bit [1:0]   gapchk = '0;
    bit [1:0]   lit_en = '0;
    int         lit_val = 0;

    typedef struct packed { logic [4:0] a; logic [74:0] f; } op_t;
    typedef struct packed { int d; int k; } res_t;
    op_t  opq[$];
    res_t outq[$];

    task automatic chk(input string name, input logic [149:0] act,
                       input logic [149:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [74:0] slice(input logic [149:0] w, input bit hi);
        logic [74:0] s;
        for (int e = 0; e < 25; e++)
            s[74-3*e -: 3] = hi ? w[149-6*e -: 3] : w[146-6*e -: 3];
        return s;
    endfunction

    function automatic logic [5:0] xbar(input logic [4:0] a, input logic [74:0] f,
                                        input int ph);
        int s;
        if (mode == 0) return 6'(ph + 1);
        if (mode == 1) return 6'd63;
        s = 0;
        for (int e = 0; e < 25; e++)
            s += int'(f[74-3*e -: 3]) * int'(W[a][e]);
        return 6'(s);
    endfunction

    function automatic int expect_k(input logic [149:0] w, input int k);
        int r;
        int sh;
        r = 0;
        for (int p = 0; p < 4; p++) begin
            sh = (p == 0) ? 6 : (p == 3) ? 0 : 3;
            r += int'(xbar(5'(2*k + p%2), slice(w, p < 2), p)) << sh;
        end
        return r;
    endfunction

    function automatic logic [149:0] rand_win();
        logic [149:0] w;
        for (int e = 0; e < 25; e++) w[e*6 +: 6] = 6'($urandom);
        return w;
    endfunction

    // ---------------- crossbar fixture ----------------
    logic [5:0]      pv  [2][4];
    bit              pok [2][4];
    int              opcnt [2];
    logic [1:0][5:0] nxt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
                opcnt[g] = 0;
                for (int s = 0; s < 4; s++) pok[g][s] = 1'b0;
            end
            nxt = '0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                for (int s = 3; s > 0; s--) begin
                    pv[g][s]  = pv[g][s-1];
                    pok[g][s] = pok[g][s-1];
                end
                pok[g][0] = pim_en[g];
                pv[g][0]  = 6'($urandom);
                if (pim_en[g]) begin
                    pv[g][0] = xbar(pim_addr[g], pim_feature[g], opcnt[g] % 4);
                    opcnt[g]++;
                end
                nxt[g] = pok[g][g*2] ? pv[g][g*2] : 6'($urandom);
            end
        end
        #1 pim_result = nxt;
    end

    // ---------------- consumer ----------------
    int stall_n = 0;
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            if (out_valid[g] && out_kidx[g] == 3'd0) stall_n = 0;
            if (rmode == 1) begin
                out_ready[g] = 1'($urandom_range(0, 1));
            end else if (rmode == 2 && out_valid[g] && out_kidx[g] == 3'd2
                         && stall_n < 5) begin
                out_ready[g] = 1'b0;
                stall_n++;
            end else begin
                out_ready[g] = 1'b1;
            end
        end
    end

    // ---------------- compare ----------------
    bit [1:0]         busy, p_ihs, p_ohs, p_olast, p_stall, p_en;
    logic [1:0][17:0] p_data;
    logic [1:0][2:0]  p_kidx;
    int               fv_cyc [2];
    op_t              o;
    res_t             r;

    always @(negedge clk) begin
        if (!rst_n) begin
            opq.delete();
            outq.delete();
            busy = '0; p_ihs = '0; p_ohs = '0;
            p_olast = '0; p_stall = '0; p_en = '0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                chk("in_ready", in_ready[g], !busy[g]);
                if (p_ihs[g] || (p_ohs[g] && !p_olast[g]))
                    chk("issue_next", pim_en[g], 1'b1);
                if (pim_en[g]) begin
                    chk("en_pulse", {p_en[g], pim_en[g]}, 2'b01);
                    if (opq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL op_extra: got addr %0d want no op", pim_addr[g]);
                    end else begin
                        o = opq.pop_front();
                        chk("pim_addr", pim_addr[g], o.a);
                        chk("pim_feature", pim_feature[g], o.f);
                    end
                end else begin
                    chk("pim_idle", {pim_addr[g], pim_feature[g]}, '0);
                end
                if (p_stall[g]) begin
                    chk("stall_valid", out_valid[g], 1'b1);
                    chk("stall_data", out_data[g], p_data[g]);
                    chk("stall_kidx", out_kidx[g], p_kidx[g]);
                    chk("stall_en", pim_en[g], 1'b0);
                end
                p_olast[g] = 1'b0;
                if (out_valid[g]) begin
                    if (!p_stall[g]) begin
                        if (gapchk[g] && outq.size() > 0 && outq[0].k != 0)
                            chk("gap", cyc - fv_cyc[g], (g == 0) ? 9 : 17);
                        fv_cyc[g] = cyc;
                    end
                    if (out_ready[g]) begin
                        if (outq.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL out_extra: got data %0d want none", out_data[g]);
                        end else begin
                            r = outq.pop_front();
                            chk("out_data", out_data[g], r.d);
                            chk("out_kidx", out_kidx[g], r.k);
                            chk("out_last", out_last[g], r.k == NK - 1);
                            if (lit_en[g]) chk("out_literal", out_data[g], lit_val);
                            if (r.k == NK - 1) begin
                                busy[g]    = 1'b0;
                                p_olast[g] = 1'b1;
                            end
                        end
                    end
                end
                p_ihs[g] = in_valid[g] && in_ready[g];
                if (p_ihs[g]) begin
                    busy[g] = 1'b1;
                    for (int k = 0; k < NK; k++) begin
                        r.d = expect_k(in_window[g], k);
                        r.k = k;
                        outq.push_back(r);
                        for (int p = 0; p < 4; p++) begin
                            o.a = 5'(2*k + p%2);
                            o.f = slice(in_window[g], p < 2);
                            opq.push_back(o);
                        end
                    end
                end
                p_ohs[g]   = out_valid[g] && out_ready[g];
                p_stall[g] = out_valid[g] && !out_ready[g];
                p_en[g]    = pim_en[g];
                p_data[g]  = out_data[g];
                p_kidx[g]  = out_kidx[g];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int g, input logic [149:0] w, input int hold);
        int n;
        in_window[g] = w;
        in_valid[g]  = 1'b1;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (in_ready[g]) break;
        end
        if (n == 500) chk("accept_timeout", in_ready[g], 1'b1);
        @(posedge clk); #1;
        in_window[g] = rand_win();
        repeat (hold) @(posedge clk);
        #1 in_valid[g] = 1'b0;
    endtask

    task automatic wait_done(input int g);
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!busy[g]) break;
        end
        if (n == 2000) chk("done_timeout", busy[g], 1'b0);
    endtask

    initial begin
        int n;
        for (int a = 0; a < 32; a++)
            for (int e = 0; e < 25; e++) W[a][e] = 3'($urandom);
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_in_ready", in_ready[g], 1'b1);
            chk("rst_pim", {pim_en[g], pim_addr[g], pim_feature[g]}, '0);
            chk("rst_out", {out_valid[g], out_data[g], out_kidx[g], out_last[g]}, '0);
        end
        rst_n = 1'b1;

        mode = 0; gapchk = 2'b01; lit_en = 2'b01; lit_val = 108;
        send(0, rand_win(), 0); wait_done(0);
        mode = 1; lit_val = 5103;
        send(0, rand_win(), 0); wait_done(0);
        lit_en = '0; mode = 2;
        send(0, {25{6'b101011}}, 20); wait_done(0);
        rmode = 2; gapchk = '0;
        send(0, rand_win(), 0); wait_done(0);
        rmode = 1;
        repeat (4) send(0, rand_win(), 0);
        wait_done(0);

        rmode = 0; mode = 0; gapchk = 2'b10; lit_en = 2'b10; lit_val = 108;
        send(1, rand_win(), 0); wait_done(1);
        lit_en = '0; mode = 2;
        repeat (2) send(1, rand_win(), 0);
        wait_done(1);
        rmode = 1; gapchk = '0;
        send(1, rand_win(), 0); wait_done(1);

        rmode = 0; gapchk = 2'b01; mode = 2;
        send(0, rand_win(), 0);
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (pim_en[0] && pim_addr[0] == 5'd4) break;
        end
        if (n == 200) chk("k2_timeout", pim_addr[0], 5'd4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out", {out_valid[0], out_data[0], out_kidx[0], out_last[0]}, '0);
        chk("abort_pim", {pim_en[0], pim_addr[0], pim_feature[0]}, '0);
        chk("abort_in_ready", in_ready[0], 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready[0], 1'b1);
        send(0, rand_win(), 0); wait_done(0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pim_conv_seq.md
Name: pim_conv_seq

Overview:
- Initiator and sequencer for one shared bit-sliced 5x5 PIM crossbar conv unit.
- Accepts one 5x5 window of 6-bit activations through a valid/ready handshake.
- For each of NUM_KERNELS stored kernels, issues four slice operations to the crossbar (data-hi/lo × weight-hi/lo), shift-accumulates the ADC results, and emits one result per kernel through a valid/ready handshake.
- Sits between the LeNet-5 C1 line buffer and the pooling stage.

Parameters:
- NUM_KERNELS, 6, kernels stored in the crossbar; 2 crossbar rows per kernel.
- ADDR_W, 5, crossbar address width; 2*NUM_KERNELS <= 2**ADDR_W.
- ADC_P, 6, width of one unsigned slice result from the crossbar.
- PIM_LAT, 1, cycles from the crossbar enable cycle until its result is valid (>=1).
- OUT_W, 18, output data width; zero-extended.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  window valid.
- in_ready  out  1  window accepted when in_valid & in_ready.
- in_window  in  150  25×6-bit activations; element 0 at [149:144], element 24 at [5:0].
- pim_en  out  1  crossbar compute enable; one-cycle pulse per slice op.
- pim_addr  out  ADDR_W  crossbar row: {kernel index, weight slice}, i.e. 2*kidx + wsel.
- pim_feature  out  75  25×3-bit activation slice; element 0 at [74:72].
- pim_result  in  ADC_P  crossbar slice result, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  convolution result for kernel out_kidx.
- out_kidx  out  3  kernel index of out_data.
- out_last  out  1  high with out_valid for kernel NUM_KERNELS-1.

Behaviour:
- Reset: async, all state cleared. FSM=IDLE, in_ready=1, pim_en=0, pim_addr=0, pim_feature=0, out_valid=0, out_data=0, out_kidx=0, out_last=0, accumulator=0.
- Reset mid-operation aborts the window. No partial output is produced. After rst_n rises, in_ready=1.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On handshake: latch in_window; kidx=0, phase=0, acc=0; go to ISSUE.
- ISSUE (one cycle):
  - pim_en=1.
  - pim_addr = 2*kidx + wsel.
  - pim_feature = data slice. Hi slice = bits [5:3] of each element; lo slice = bits [2:0].
  - Phase order: 0 = HH (data hi, wsel 0); 1 = HL (data hi, wsel 1); 2 = LH (data lo, wsel 0); 3 = LL (data lo, wsel 1).
  - Go to WAIT.
- WAIT (PIM_LAT cycles):
  - pim_en=0. pim_addr and pim_feature are driven to 0 in every non-ISSUE state.
  - On the last WAIT cycle edge, acc += pim_result << shift. Shift is 6 for HH, 3 for HL/LH, 0 for LL.
  - If phase==3, go to OUT. Otherwise phase++ and go to ISSUE.
- OUT:
  - out_valid=1, out_data=acc, out_kidx=kidx, out_last=(kidx==NUM_KERNELS-1).
  - Outputs are held stable while out_ready=0. No crossbar activity occurs during the stall.
  - On out_ready=1: if last, go to IDLE (in_ready=1 next cycle). Otherwise kidx++, phase=0, acc=0, go to ISSUE.
- Throughput: 4*(1+PIM_LAT)+1 cycles per kernel with out_ready tied high. That is 9 cycles at PIM_LAT=1.
- Arithmetic: unsigned throughout. Accumulator is ADC_P+7 bits and is zero-extended to OUT_W. Max value 5103 at ADC_P=6; no overflow possible.
- in_ready=0 in every state except IDLE. in_valid held high outside IDLE is ignored; the window is not consumed.
- in_window changes after acceptance have no effect; the latched copy is used.

Decomposition:
- Shared package pim_pkg holds:
  - phase enum (HH, HL, LH, LL) and FSM state enum;
  - SLICE_W=3, NUM_ELEM=25;
  - per-phase shift constants (6, 3, 3, 0);
  - per-phase wsel and data-slice select tables.
- One sub-module, pim_shift_acc: clear/accumulate of a shifted ADC_P-bit value into an ADC_P+7-bit register.

Test Plan:
1. Reset and handshake: PIM model returns HH=1, HL=2, LH=3, LL=4; PIM_LAT=1; out_ready=1.
   - Expect out_data=108 for every kernel.
   - Expect out_valid exactly 9 cycles apart.
   - Expect out_kidx 0..5, out_last only on kidx 5.
2. Max values: PIM model returns 63 for all phases.
   - Expect out_data=5103 with no wrap.
3. Sequence check: in_window all elements 6'b101_011.
   - Kernel 3 issues pim_addr 6,7,6,7.
   - pim_feature is 75 bits of repeated 101, 101, then 011, 011.
   - pim_en is one cycle per op.
4. Backpressure: hold out_ready=0 for 5 cycles on kernel 2.
   - out_valid, out_data and out_kidx stay stable.
   - pim_en stays 0 and in_ready stays 0.
   - Kernel 3 issue starts the cycle after out_ready rises.
5. PIM_LAT=3: capture occurs 3 cycles after each pim_en.
   - Per-kernel spacing is 17 cycles.
   - Changing pim_result in non-capture cycles has no effect on out_data.
6. Reset during WAIT of kernel 2: drive rst_n low for 2 cycles.
   - All outputs become 0 immediately.
   - in_ready=1 after release.
   - The next window starts at kidx 0 with acc cleared.
